dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the memory-side end of the CPU's load/store port. It accepts one request at a time over a valid/ready handshake and performs the word read or byte-masked write. It returns a response after a fixed, parameterised number of wait states, over a second valid/ready handshake. It lets the core be exercised against a non-zero-latency memory and flags misaligned or out-of-range accesses instead of aliasing them.

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed number
// of cycles, then commits and returns a registered response with fault flag.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  req_t          req_q, req_in, cur;
  logic          latch, commit, mem_we, cur_err;
  logic [AW-1:0] cur_idx;
  logic          ready_d, valid_d, err_d;
  logic [DW-1:0] rdata_d;

  logic [DW-1:0] mem [DEPTH_WORDS];

  assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero wait states the commit happens on the accepting edge, so the
  // live request must be used before it has been latched.
  assign cur     = (state_q == S_IDLE) ? req_in : req_q;
  assign cur_idx = cur.addr[AW+1:2];
  assign cur_err = (|cur.addr[1:0]) || (|cur.addr[DW-1:AW+2]);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rsp_rdata;
    err_d   = rsp_err;
    latch   = 1'b0;
    commit  = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      err_d   = cur_err;
      rdata_d = (cur.we || cur_err) ? '0 : mem[cur_idx];
      mem_we  = cur.we && !cur_err && rst;
    end
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RESP);
  end

  // State, request latch and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (latch) req_q <= req_in;
      req_ready <= ready_d;
      rsp_valid <= valid_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur.be[b]) mem[cur_idx][8*b +: 8] <= cur.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_STATES=2 and a WAIT_STATES=0 instance checked
// every cycle against a transaction-level memory model plus literal expectations.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction-level model state, one slot per instance
  bit          in_flight [2];
  int          cedge     [2];
  int          acc_edge  [2];
  int          acc_count [2];
  logic        m_we      [2];
  logic [31:0] m_addr    [2];
  logic [31:0] m_wdata   [2];
  logic [3:0]  m_be      [2];
  logic [31:0] exp_rdata [2];
  logic        exp_err   [2];
  bit          exp_known [2];
  logic [31:0] mmem      [2][256];
  bit          mknown    [2][256];
  bit          seen_valid[2];
  int          last_lat  [2];
  logic [31:0] last_rdata[2];
  logic        last_err  [2];

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // Commit the outstanding request against the model memory
  task automatic model_commit(input int d);
    int idx;
    idx = int'(m_addr[d][9:2]);
    if (m_addr[d][1:0] != 2'b00 || m_addr[d] >= 32'd1024) begin
      exp_rdata[d] = 32'h0; exp_err[d] = 1'b1; exp_known[d] = 1'b1;
    end else if (m_we[d]) begin
      for (int b = 0; b < 4; b++)
        if (m_be[d][b]) mmem[d][idx][8*b +: 8] = m_wdata[d][8*b +: 8];
      if (m_be[d] == 4'hF) mknown[d][idx] = 1'b1;
      exp_rdata[d] = 32'h0; exp_err[d] = 1'b0; exp_known[d] = 1'b1;
    end else begin
      exp_rdata[d] = mmem[d][idx]; exp_err[d] = 1'b0; exp_known[d] = mknown[d][idx];
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        if (in_flight[d] && cyc > cedge[d] && rsp_ready[d]) begin
          in_flight[d] = 1'b0;
        end else if (!in_flight[d] && req_valid[d]) begin
          in_flight[d]  = 1'b1;
          acc_edge[d]   = cyc;
          cedge[d]      = cyc + ws_of(d);
          acc_count[d]  = acc_count[d] + 1;
          seen_valid[d] = 1'b0;
          m_we[d] = req_we[d]; m_addr[d] = req_addr[d];
          m_wdata[d] = req_wdata[d]; m_be[d] = req_be[d];
        end
        if (in_flight[d] && cyc == cedge[d]) model_commit(d);
      end
    end
  end

  // An in-flight request is abandoned by reset
  always @(negedge rst) begin
    for (int d = 0; d < 2; d++) in_flight[d] = 1'b0;
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    bit ev;
    if (rst === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        ev = in_flight[d] && (cyc >= cedge[d]);
        chk($sformatf("req_ready[%0d] cyc %0d", d, cyc), 32'(req_ready[d]), 32'(!in_flight[d]));
        chk($sformatf("rsp_valid[%0d] cyc %0d", d, cyc), 32'(rsp_valid[d]), 32'(ev));
        if (ev) begin
          chk($sformatf("rsp_err[%0d] cyc %0d", d, cyc), 32'(rsp_err[d]), 32'(exp_err[d]));
          if (exp_known[d])
            chk($sformatf("rsp_rdata[%0d] cyc %0d", d, cyc), rsp_rdata[d], exp_rdata[d]);
          if (!seen_valid[d] && rsp_valid[d]) begin
            seen_valid[d] = 1'b1;
            last_lat[d]   = cyc + 1 - acc_edge[d];
          end
          last_rdata[d] = rsp_rdata[d];
          last_err[d]   = rsp_err[d];
        end
      end
    end
  end

  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    int c0;
    bit ok;
    @(posedge clk);
    #2;
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
    req_valid[d] = 1'b1;
    c0 = acc_count[d];
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (acc_count[d] != c0) begin ok = 1'b1; break; end
    end
    req_valid[d] = 1'b0;
    if (!ok) fail_timeout("request acceptance");
  endtask

  task automatic wait_done(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!in_flight[d]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_timeout("response handshake");
  endtask

  task automatic store(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    do_req(d, 1'b1, addr, wdata, be);
    wait_done(d);
  endtask

  task automatic load_chk(input int d, input logic [31:0] addr, input logic [31:0] exp,
                          input logic exp_e, input string name);
    do_req(d, 1'b0, addr, 32'h0, 4'h0);
    wait_done(d);
    chk({name, " rdata"}, last_rdata[d], exp);
    chk({name, " err"}, 32'(last_err[d]), 32'(exp_e));
  endtask

  task automatic chk_reset_outputs(input string name);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s req_ready[%0d]", name, d), 32'(req_ready[d]), 32'h1);
      chk($sformatf("%s rsp_valid[%0d]", name, d), 32'(rsp_valid[d]), 32'h0);
      chk($sformatf("%s rsp_rdata[%0d]", name, d), rsp_rdata[d], 32'h0);
      chk($sformatf("%s rsp_err[%0d]", name, d), 32'(rsp_err[d]), 32'h0);
    end
  endtask

  initial begin
    int a1, a2;
    bit ok;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_be[d] = 4'h0; rsp_ready[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    #2 rst = 1'b1;

    // Full store then load, back to back
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    a1 = acc_edge[0];
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    a2 = acc_edge[0];
    wait_done(0);
    chk("ws2 spacing", 32'(a2 - a1), 32'd4);
    chk("ws2 latency", 32'(last_lat[0]), 32'd3);
    chk("load 0x10 rdata", last_rdata[0], 32'hDEADBEEF);
    chk("load 0x10 err", 32'(last_err[0]), 32'h0);

    // Byte-masked and empty-mask stores
    store(0, 32'h10, 32'h000000AA, 4'b0001);
    load_chk(0, 32'h10, 32'hDEADBEAA, 1'b0, "be0001");
    store(0, 32'h10, 32'hFFFFFFFF, 4'b0000);
    load_chk(0, 32'h10, 32'hDEADBEAA, 1'b0, "be0000");

    // Faulting accesses must not alias onto word 0
    store(0, 32'h0, 32'h11111111, 4'hF);
    load_chk(0, 32'h12, 32'h0, 1'b1, "misaligned");
    load_chk(0, 32'h400, 32'h0, 1'b1, "out of range");
    store(0, 32'h400, 32'h99999999, 4'hF);
    load_chk(0, 32'h0, 32'h11111111, 1'b0, "no alias");
    store(0, 32'h20, 32'hCAFEF00D, 4'hF);

    // Response backpressure
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("backpressure response");
    repeat (5) @(negedge clk);
    #1;
    chk("bp rsp_valid held", 32'(rsp_valid[0]), 32'h1);
    chk("bp req_ready low", 32'(req_ready[0]), 32'h0);
    chk("bp rdata held", rsp_rdata[0], 32'hDEADBEAA);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    #1;
    chk("bp done rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("bp done req_ready", 32'(req_ready[0]), 32'h1);

    // Reset during the wait of a store
    do_req(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
    #1 rst = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    @(negedge clk);
    #1 rst = 1'b1;
    load_chk(0, 32'h20, 32'hCAFEF00D, 1'b0, "dropped store");

    // Zero-wait-state instance, back to back
    do_req(1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF);
    a1 = acc_edge[1];
    do_req(1, 1'b0, 32'h40, 32'h0, 4'h0);
    a2 = acc_edge[1];
    wait_done(1);
    chk("ws0 spacing", 32'(a2 - a1), 32'd2);
    chk("ws0 latency", 32'(last_lat[1]), 32'd1);
    chk("ws0 load rdata", last_rdata[1], 32'hA5A5A5A5);
    store(1, 32'h44, 32'h0BADF00D, 4'hF);
    store(1, 32'h44, 32'h00770000, 4'b0100);
    load_chk(1, 32'h44, 32'h0B77F00D, 1'b0, "ws0 be0100");
    load_chk(1, 32'h41, 32'h0, 1'b1, "ws0 misaligned");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
